// File: rtl/spi_master_cfg.sv
// Parametrised SPI master: runtime SCLK divider, all CPOL/CPHA modes, MSB/LSB-first, one-hot CS.
// One word per start/ready handshake; the received word is returned with a one-cycle done pulse.
module spi_master_cfg #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n,
  output logic [DATA_W-1:0] rx_data,
  output logic              done,
  output logic              busy
);
  localparam int EW = $clog2(DATA_W) + 1;
  localparam logic [EW-1:0] LAST_HALF = EW'(2 * DATA_W - 1);

  // IDLE: ready | SETUP: CS low, SCLK idle | XFER: 2*DATA_W half-periods | HOLD: CS held, SCLK idle
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  half_cnt;
  logic [EW-1:0]     edge_cnt;
  logic              cpol_q;
  logic              cpha_q;
  logic              lsb_q;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;

  logic              half_tc;
  logic              trailing;
  logic              last_trailing;
  logic              tx_head;
  logic [DATA_W-1:0] tx_rest;
  logic [DATA_W-1:0] rx_next;
  logic              acc_head;
  logic [DATA_W-1:0] acc_rest;
  logic [NUM_CS-1:0] cs_dec;

  // edge_cnt counts remaining half-periods down; an odd count means the next toggle is a trailing edge
  assign half_tc       = (half_cnt == '0);
  assign trailing      = edge_cnt[0];
  assign last_trailing = (edge_cnt == EW'(1));
  assign tx_head       = lsb_q ? tx_sh[0] : tx_sh[DATA_W-1];
  assign tx_rest       = lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
  assign rx_next       = lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
  assign acc_head      = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
  assign acc_rest      = lsb_first ? (tx_data >> 1) : (tx_data << 1);

  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      cs_dec[i] = (cs_sel != CS_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      div_q    <= '0;
      half_cnt <= '0;
      edge_cnt <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
      rx_data  <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ready    <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= cpol;
          mosi <= 1'b0;
          if (start) begin
            state    <= SETUP;
            ready    <= 1'b0;
            busy     <= 1'b1;
            cs_n     <= cs_dec;
            div_q    <= clk_div;
            half_cnt <= clk_div;
            edge_cnt <= LAST_HALF;
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            lsb_q    <= lsb_first;
            rx_sh    <= '0;
            if (cpha) begin
              tx_sh <= tx_data;
            end else begin
              mosi  <= acc_head;
              tx_sh <= acc_rest;
            end
          end
        end
        SETUP: begin
          if (half_tc) begin
            half_cnt <= div_q;
            state    <= XFER;
            sclk     <= ~cpol_q;
            if (cpha_q) begin
              mosi  <= tx_head;
              tx_sh <= tx_rest;
            end else begin
              rx_sh <= rx_next;
            end
          end else begin
            half_cnt <= half_cnt - DIV_W'(1);
          end
        end
        XFER: begin
          if (half_tc) begin
            half_cnt <= div_q;
            if (edge_cnt == '0) begin
              state <= HOLD;
            end else begin
              edge_cnt <= edge_cnt - EW'(1);
              sclk     <= ~sclk;
              // cpha=0 samples on leading edges, cpha=1 on trailing; the other edge shifts mosi
              if (trailing == cpha_q) begin
                rx_sh <= rx_next;
              end else if (!last_trailing) begin
                mosi  <= tx_head;
                tx_sh <= tx_rest;
              end
            end
          end else begin
            half_cnt <= half_cnt - DIV_W'(1);
          end
        end
        HOLD: begin
          if (half_tc) begin
            state   <= IDLE;
            cs_n    <= '1;
            rx_data <= rx_sh;
            done    <= 1'b1;
            busy    <= 1'b0;
            ready   <= 1'b1;
            mosi    <= 1'b0;
            sclk    <= cpol;
          end else begin
            half_cnt <= half_cnt - DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: a timeline model of each transfer (offset from acceptance) is compared
// against the DUT every cycle; directed transfers add hand-computed expectations on top.
module tb_spi_master_cfg;
  localparam int N     = 8;
  localparam int NCS   = 5;
  localparam int DIVW  = 8;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic           start = 1'b0;
  logic           ready;
  logic [N-1:0]   tx_data = '0;
  logic [2:0]     cs_sel = '0;
  logic           cpol = 1'b0;
  logic           cpha = 1'b0;
  logic           lsb_first = 1'b0;
  logic [DIVW-1:0] clk_div = '0;
  logic           miso;
  logic           sclk;
  logic           mosi;
  logic [NCS-1:0] cs_n;
  logic [N-1:0]   rx_data;
  logic           done;
  logic           busy;

  logic           loopback = 1'b1;
  logic [N-1:0]   slave_word = '0;
  logic           slave_bit;
  logic           chk_en = 1'b0;
  int             checks = 0;
  int             failures = 0;
  int             sclk_rises = 0;

  always #5 clk = ~clk;

  assign miso = loopback ? mosi : slave_bit;

  spi_master_cfg #(.DATA_W(N), .NUM_CS(NCS), .DIV_W(DIVW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ready(ready), .tx_data(tx_data),
    .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div),
    .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .rx_data(rx_data), .done(done),
    .busy(busy)
  );

  always @(posedge sclk) sclk_rises <= sclk_rises + 1;

  // transfer model: m_t is the number of clk edges since acceptance
  logic         m_act, m_done, m_sclk_idle, m_pol, m_pha, m_lsb;
  int           m_t, m_h, m_sel;
  logic [N-1:0] m_tx, m_sw, m_rx, m_rxexp;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_act <= 1'b0; m_done <= 1'b0; m_rx <= '0; m_sclk_idle <= 1'b0; m_t <= 0;
      m_h <= 1; m_sel <= 0; m_pol <= 1'b0; m_pha <= 1'b0; m_lsb <= 1'b0;
      m_tx <= '0; m_sw <= '0; m_rxexp <= '0;
    end else if (m_act) begin
      m_t <= m_t + 1;
      if (m_t + 1 == (2 * N + 2) * m_h) begin
        m_act <= 1'b0; m_done <= 1'b1; m_rx <= m_rxexp; m_sclk_idle <= cpol;
      end
    end else begin
      m_done <= 1'b0;
      m_sclk_idle <= cpol;
      if (start) begin
        m_act <= 1'b1; m_t <= 0; m_h <= int'(clk_div) + 1; m_sel <= int'(cs_sel);
        m_pol <= cpol; m_pha <= cpha; m_lsb <= lsb_first; m_tx <= tx_data; m_sw <= slave_word;
        m_rxexp <= loopback ? tx_data : slave_word;
      end
    end
  end

  // bit on the wire at offset t: bit k of the word in transmit order
  function automatic logic wire_bit(input logic [N-1:0] w, input int t, input int h,
                                    input logic pha, input logic lsb);
    int idx, j;
    if (t < h) begin
      if (pha) return 1'b0;
      idx = 0;
    end else if (t < (2 * N + 1) * h) begin
      j = (t - h) / h;
      idx = pha ? j / 2 : (((j + 1) / 2 > N - 1) ? N - 1 : (j + 1) / 2);
    end else begin
      idx = N - 1;
    end
    return lsb ? w[idx] : w[N - 1 - idx];
  endfunction

  function automatic logic sclk_at(input int t, input int h, input logic pol);
    if (t < h || t >= (2 * N + 1) * h) return pol;
    return ((((t - h) / h) % 2) == 0) ? ~pol : pol;
  endfunction

  logic           e_sclk, e_mosi, e_busy, e_ready, e_done;
  logic [NCS-1:0] e_cs;

  always_comb begin
    e_cs = '1; e_sclk = m_sclk_idle; e_mosi = 1'b0; e_busy = 1'b0; e_ready = 1'b1;
    e_done = m_done; slave_bit = 1'b0;
    if (m_act) begin
      e_busy = 1'b1; e_ready = 1'b0; e_done = 1'b0;
      if (m_sel < NCS) e_cs[m_sel] = 1'b0;
      e_sclk    = sclk_at(m_t, m_h, m_pol);
      e_mosi    = wire_bit(m_tx, m_t, m_h, m_pha, m_lsb);
      slave_bit = wire_bit(m_sw, m_t, m_h, m_pha, m_lsb);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sclk", 32'(sclk), 32'(e_sclk));
      chk("mosi", 32'(mosi), 32'(e_mosi));
      chk("cs_n", 32'(cs_n), 32'(e_cs));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("ready", 32'(ready), 32'(e_ready));
      chk("done", 32'(done), 32'(e_done));
      chk("rx_data", 32'(rx_data), 32'(m_rx));
    end
  end

  task automatic kick(input logic [N-1:0] tx, input logic [2:0] sel, input logic pol, input logic pha,
                      input logic lsb, input logic [DIVW-1:0] div, input logic loop,
                      input logic [N-1:0] sw, output int rise_base);
    @(negedge clk);
    tx_data = tx; cs_sel = sel; cpol = pol; cpha = pha; lsb_first = lsb; clk_div = div;
    loopback = loop; slave_word = sw; start = 1'b1;
    rise_base = sclk_rises;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int t0, output int lat);
    lat = -1;
    for (int t = t0; t < t0 + 4000; t++) begin
      if (done) begin
        lat = t;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", 32'(lat >= 0), 32'd1);
  endtask

  task automatic run_xfer(input logic [N-1:0] tx, input logic [2:0] sel, input logic pol,
                          input logic pha, input logic lsb, input logic [DIVW-1:0] div,
                          input logic loop, input logic [N-1:0] sw,
                          output int lat, output logic fm, output logic [NCS-1:0] cs0,
                          output int rise_base);
    int t0;
    kick(tx, sel, pol, pha, lsb, div, loop, sw, rise_base);
    cs0 = cs_n;
    t0 = 0;
    if (pha) begin
      t0 = int'(div) + 1;
      repeat (t0) @(negedge clk);
    end
    fm = mosi;
    wait_done(t0, lat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, lat2, rb, gap, nd;
    logic fm;
    logic [NCS-1:0] cs0;

    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_rx", 32'(rx_data), 32'h0);
    chk("reset_cs", 32'(cs_n), 32'h1f);
    chk("reset_ready", 32'(ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // mode 0, MSB first, loopback
    run_xfer(8'hA5, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'h00, lat, fm, cs0, rb);
    chk("t1_rx", 32'(rx_data), 32'hA5);
    chk("t1_lat", 32'(lat), 32'd18);
    chk("t1_rises", 32'(sclk_rises - rb), 32'd8);
    chk("t1_sclk_idle", 32'(sclk), 32'd0);

    // mode 3, divider 3, slave returns 0xC3
    run_xfer(8'h3C, 3'd1, 1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 8'hC3, lat, fm, cs0, rb);
    chk("t2_rx", 32'(rx_data), 32'hC3);
    chk("t2_lat", 32'(lat), 32'd72);
    chk("t2_sclk_idle", 32'(sclk), 32'd1);

    // modes 1 and 2, LSB first
    run_xfer(8'h01, 3'd0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 8'h80, lat, fm, cs0, rb);
    chk("t3m1_first_mosi", 32'(fm), 32'd1);
    chk("t3m1_rx", 32'(rx_data), 32'h80);
    run_xfer(8'h01, 3'd3, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 8'h80, lat, fm, cs0, rb);
    chk("t3m2_first_mosi", 32'(fm), 32'd1);
    chk("t3m2_rx", 32'(rx_data), 32'h80);

    // chip-select decode, in range and out of range
    run_xfer(8'h5A, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'h00, lat, fm, cs0, rb);
    chk("t4_cs2", 32'(cs0), 32'h1b);
    chk("t4_rx2", 32'(rx_data), 32'h5A);
    run_xfer(8'h96, 3'd5, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'h00, lat, fm, cs0, rb);
    chk("t4_cs5", 32'(cs0), 32'h1f);
    chk("t4_lat5", 32'(lat), 32'd18);
    chk("t4_rx5", 32'(rx_data), 32'h96);

    // start and inputs changed mid-transfer, start held through done
    kick(8'h6B, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 8'h00, rb);
    repeat (6) @(negedge clk);
    start = 1'b1; tx_data = 8'hFF; clk_div = 8'd0;
    wait_done(6, lat);
    chk("t5_rx1", 32'(rx_data), 32'h6B);
    chk("t5_lat1", 32'(lat), 32'd36);
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      if (cs_n != 5'h1f) break;
      gap++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("t5_cs_gap", 32'(gap), 32'd1);
    wait_done(0, lat2);
    chk("t5_rx2", 32'(rx_data), 32'hFF);
    chk("t5_lat2", 32'(lat2), 32'd18);

    // reset during bit 4 of XFER
    kick(8'hC6, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'h00, rb);
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_cs", 32'(cs_n), 32'h1f);
    chk("t6_sclk", 32'(sclk), 32'd0);
    chk("t6_mosi", 32'(mosi), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("t6_no_done", 32'(nd), 32'd0);
    run_xfer(8'h3A, 3'd4, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 8'h00, lat, fm, cs0, rb);
    chk("t6_rx", 32'(rx_data), 32'h3A);
    chk("t6_lat", 32'(lat), 32'd54);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
